// File: rtl/brc_seq_pkg.sv
// Shared definitions for the byte-serial branch comparator: FSM states and
// operand geometry.
package brc_seq_pkg;

   localparam int unsigned NUM_BYTES = 4;
   localparam logic [1:0]  LAST_IDX  = 2'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/compare_8bit.sv
// Unsigned 8-bit magnitude comparator.
module compare_8bit (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic       equal_o,
   output logic       alarger_o,
   output logic       blarger_o
);

   always_comb begin
      equal_o   = (a_i == b_i);
      alarger_o = (a_i > b_i);
      blarger_o = (a_i < b_i);
   end

endmodule

// File: rtl/brc_seq.sv
// Byte-serial branch comparator: walks the operands from the most significant
// byte down and stops at the first unequal byte.
module brc_seq
   import brc_seq_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic        unsigned_i,
   input  logic        flush_i,
   output logic        done_o,
   output logic        br_equal_o,
   output logic        br_less_o
);

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] rs1_q, rs1_d;
   logic [31:0] rs2_q, rs2_d;
   logic        uns_q, uns_d;
   logic        done_q, done_d;
   logic        eq_q, eq_d;
   logic        less_q, less_d;

   logic [7:0]  byte_a, byte_b;
   logic        byte_eq, byte_blarger;
   logic        sign_flip;

   // Flipping the sign bits of the top byte maps signed order onto unsigned order.
   always_comb begin
      sign_flip = !uns_q && (idx_q == LAST_IDX);
      byte_a    = rs1_q[{idx_q, 3'b000} +: 8] ^ {sign_flip, 7'b0};
      byte_b    = rs2_q[{idx_q, 3'b000} +: 8] ^ {sign_flip, 7'b0};
   end

   compare_8bit u_cmp (
      .a_i       (byte_a),
      .b_i       (byte_b),
      .equal_o   (byte_eq),
      .alarger_o (),
      .blarger_o (byte_blarger)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      uns_d   = uns_q;
      eq_d    = eq_q;
      less_d  = less_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (valid_i && !flush_i) begin
               rs1_d   = rs1_i;
               rs2_d   = rs2_i;
               uns_d   = unsigned_i;
               idx_d   = LAST_IDX;
               state_d = CMP;
            end
         end
         CMP: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (!byte_eq) begin
               eq_d    = 1'b0;
               less_d  = byte_blarger;
               state_d = DONE;
            end else if (idx_q == 2'd0) begin
               eq_d    = 1'b1;
               less_d  = 1'b0;
               state_d = DONE;
            end else begin
               idx_d = idx_q - 2'd1;
            end
         end
         DONE: begin
            // The pulse is registered so it leaves DONE one cycle late and a
            // flush in DONE can still cancel it without a combinational path.
            done_d  = !flush_i;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= LAST_IDX;
         rs1_q   <= '0;
         rs2_q   <= '0;
         uns_q   <= 1'b0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         less_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         uns_q   <= uns_d;
         done_q  <= done_d;
         eq_q    <= eq_d;
         less_q  <= less_d;
      end
   end

   assign ready_o    = (state_q == IDLE);
   assign done_o     = done_q;
   assign br_equal_o = eq_q;
   assign br_less_o  = less_q;

endmodule
